// File: rtl/picomips_io_sequencer.sv
// picoMIPS execution / I/O handshake sequencer: SW[8] synchronizer, IN capture, OUT LED register.
// Optional handshake debounce enabled by defining PICOMIPS_HS_DEBOUNCE_EN (DEBOUNCE_CYCLES samples).
module picomips_io_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hs_raw,
  input  logic [7:0] sw_data,
  input  logic       is_input,
  input  logic       is_output,
  input  logic       is_halt,
  input  logic [7:0] out_data,
  output logic       pc_enable,
  output logic       wr_enable,
  output logic [7:0] in_data,
  output logic [7:0] led,
  output logic [2:0] state,
  output logic       hs_sync
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARMED      = 3'd1,
    RUN        = 3'd2,
    IN_WAIT_HI = 3'd3,
    IN_WAIT_LO = 3'd4,
    HALTED     = 3'd5
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   sync1_q;
  logic   sync2_q;
  logic   led_load;
  logic   in_load;

  if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= hs_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef PICOMIPS_HS_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] db_cnt_q;
  logic             hs_db_q;

  // Counter tracks consecutive samples that disagree with the filtered level;
  // a sample matching the current level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt_q <= '0;
      hs_db_q  <= 1'b0;
    end else if (sync2_q == hs_db_q) begin
      db_cnt_q <= '0;
    end else if (32'(db_cnt_q) == DEBOUNCE_CYCLES - 1) begin
      hs_db_q  <= sync2_q;
      db_cnt_q <= '0;
    end else begin
      db_cnt_q <= db_cnt_q + CNT_W'(1);
    end
  end

  assign hs_sync = hs_db_q;
`else
  assign hs_sync = sync2_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (hs_sync)  state_d = ARMED;
      ARMED:      if (!hs_sync) state_d = RUN;
      RUN: begin
        if (is_halt)       state_d = HALTED;
        else if (is_input) state_d = IN_WAIT_HI;
      end
      IN_WAIT_HI: if (hs_sync)  state_d = IN_WAIT_LO;
      IN_WAIT_LO: if (!hs_sync) state_d = RUN;
      HALTED:     state_d = HALTED;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    pc_enable = 1'b0;
    wr_enable = 1'b0;
    led_load  = 1'b0;
    in_load   = 1'b0;
    case (state_q)
      RUN: begin
        if (!is_halt && !is_input) begin
          pc_enable = 1'b1;
          if (is_output) led_load  = 1'b1;
          else           wr_enable = 1'b1;
        end
      end
      IN_WAIT_HI: in_load = hs_sync;
      IN_WAIT_LO: begin
        if (!hs_sync) begin
          pc_enable = 1'b1;
          wr_enable = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led     <= '0;
      in_data <= '0;
    end else begin
      if (led_load) led     <= out_data;
      if (in_load)  in_data <= sw_data;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_picomips_io_sequencer.sv
// Self-checking bench for picomips_io_sequencer: per-cycle expectations queued at drive time,
// popped and compared on the falling edge. Debounce scenario runs when PICOMIPS_HS_DEBOUNCE_EN is defined.
module tb_picomips_io_sequencer;

  localparam logic [2:0] S_I = 3'd0, S_A = 3'd1, S_R = 3'd2, S_H = 3'd3, S_L = 3'd4, S_X = 3'd5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hs_raw = 1'b0;
  logic [7:0] sw_data = 8'h00;
  logic       is_input = 1'b0;
  logic       is_output = 1'b0;
  logic       is_halt = 1'b0;
  logic [7:0] out_data = 8'h00;
  logic       pc_enable;
  logic       wr_enable;
  logic [7:0] in_data;
  logic [7:0] led;
  logic [2:0] state;
  logic       hs_sync;

  int total = 0;
  int bad = 0;

  typedef struct {
    string      tag;
    logic       pc;
    logic       wr;
    logic [2:0] st;
    logic [7:0] led;
    logic [7:0] ind;
    logic       hs;
  } exp_t;

  exp_t exp_q[$];

  picomips_io_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .hs_raw    (hs_raw),
    .sw_data   (sw_data),
    .is_input  (is_input),
    .is_output (is_output),
    .is_halt   (is_halt),
    .out_data  (out_data),
    .pc_enable (pc_enable),
    .wr_enable (wr_enable),
    .in_data   (in_data),
    .led       (led),
    .state     (state),
    .hs_sync   (hs_sync)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic pc, input logic wr, input logic [2:0] st,
                     input logic [7:0] l, input logic [7:0] ind, input logic hs);
    exp_t e;
    e.tag = tag; e.pc = pc; e.wr = wr; e.st = st; e.led = l; e.ind = ind; e.hs = hs;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val($sformatf("%s.pc", e.tag), 32'(pc_enable), 32'(e.pc));
      check_val($sformatf("%s.wr", e.tag), 32'(wr_enable), 32'(e.wr));
      check_val($sformatf("%s.state", e.tag), 32'(state), 32'(e.st));
      check_val($sformatf("%s.led", e.tag), 32'(led), 32'(e.led));
      check_val($sformatf("%s.in_data", e.tag), 32'(in_data), 32'(e.ind));
      check_val($sformatf("%s.hs_sync", e.tag), 32'(hs_sync), 32'(e.hs));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    next(); cyc("rst", 0, 0, S_I, 8'h00, 8'h00, 0);
    next(); reset = 1'b0; cyc("idle", 0, 0, S_I, 8'h00, 8'h00, 0);
`ifndef PICOMIPS_HS_DEBOUNCE_EN
    // Start handshake: high-low on SW[8]
    next(); hs_raw = 1'b1; cyc("rise0", 0, 0, S_I, 8'h00, 8'h00, 0);
    next(); cyc("rise1", 0, 0, S_I, 8'h00, 8'h00, 0);
    next(); cyc("rise2", 0, 0, S_I, 8'h00, 8'h00, 1);
    next(); hs_raw = 1'b0; cyc("armed0", 0, 0, S_A, 8'h00, 8'h00, 1);
    next(); cyc("armed1", 0, 0, S_A, 8'h00, 8'h00, 1);
    next(); cyc("armed2", 0, 0, S_A, 8'h00, 8'h00, 0);
    next(); cyc("run", 1, 1, S_R, 8'h00, 8'h00, 0);
    // OUT
    next(); is_output = 1'b1; out_data = 8'h5A; cyc("out", 1, 0, S_R, 8'h00, 8'h00, 0);
    next(); is_output = 1'b0; out_data = 8'h00; cyc("out_led", 1, 1, S_R, 8'h5A, 8'h00, 0);
    next(); cyc("led_hold", 1, 1, S_R, 8'h5A, 8'h00, 0);
    // IN with a 5-cycle handshake pulse
    next(); is_input = 1'b1; sw_data = 8'h37; cyc("in_dec", 0, 0, S_R, 8'h5A, 8'h00, 0);
    next(); hs_raw = 1'b1; cyc("in_hi0", 0, 0, S_H, 8'h5A, 8'h00, 0);
    next(); cyc("in_hi1", 0, 0, S_H, 8'h5A, 8'h00, 0);
    next(); cyc("in_hi2", 0, 0, S_H, 8'h5A, 8'h00, 1);
    next(); sw_data = 8'hFF; cyc("in_lo0", 0, 0, S_L, 8'h5A, 8'h37, 1);
    next(); cyc("in_lo1", 0, 0, S_L, 8'h5A, 8'h37, 1);
    next(); hs_raw = 1'b0; cyc("in_lo2", 0, 0, S_L, 8'h5A, 8'h37, 1);
    next(); cyc("in_lo3", 0, 0, S_L, 8'h5A, 8'h37, 1);
    next(); cyc("in_wb", 1, 1, S_L, 8'h5A, 8'h37, 0);
    next(); is_input = 1'b0; cyc("in_done", 1, 1, S_R, 8'h5A, 8'h37, 0);
    // IN abandoned by reset in IN_WAIT_LO
    next(); is_input = 1'b1; sw_data = 8'hA4; cyc("in2_dec", 0, 0, S_R, 8'h5A, 8'h37, 0);
    next(); hs_raw = 1'b1; cyc("in2_hi0", 0, 0, S_H, 8'h5A, 8'h37, 0);
    next(); cyc("in2_hi1", 0, 0, S_H, 8'h5A, 8'h37, 0);
    next(); cyc("in2_hi2", 0, 0, S_H, 8'h5A, 8'h37, 1);
    next(); reset = 1'b1; cyc("in2_lo", 0, 0, S_L, 8'h5A, 8'hA4, 1);
    next(); reset = 1'b0; is_input = 1'b0; cyc("rst_mid", 0, 0, S_I, 8'h00, 8'h00, 0);
    next(); hs_raw = 1'b0; cyc("re_idle0", 0, 0, S_I, 8'h00, 8'h00, 0);
    next(); cyc("re_idle1", 0, 0, S_I, 8'h00, 8'h00, 1);
    next(); cyc("re_armed", 0, 0, S_A, 8'h00, 8'h00, 0);
    next(); cyc("re_run", 1, 1, S_R, 8'h00, 8'h00, 0);
    next(); is_output = 1'b1; out_data = 8'hC3; cyc("out2", 1, 0, S_R, 8'h00, 8'h00, 0);
    next(); is_output = 1'b0; cyc("out2_led", 1, 1, S_R, 8'hC3, 8'h00, 0);
    // HALT beats IN; handshake and decode ignored afterwards
    next(); is_halt = 1'b1; is_input = 1'b1; cyc("halt_dec", 0, 0, S_R, 8'hC3, 8'h00, 0);
    next(); is_halt = 1'b0; is_input = 1'b0; is_output = 1'b1; out_data = 8'h11; hs_raw = 1'b1;
    cyc("halt0", 0, 0, S_X, 8'hC3, 8'h00, 0);
    next(); cyc("halt1", 0, 0, S_X, 8'hC3, 8'h00, 0);
    next(); cyc("halt2", 0, 0, S_X, 8'hC3, 8'h00, 1);
    next(); hs_raw = 1'b0; cyc("halt3", 0, 0, S_X, 8'hC3, 8'h00, 1);
    next(); cyc("halt4", 0, 0, S_X, 8'hC3, 8'h00, 1);
    next(); is_output = 1'b0; cyc("halt5", 0, 0, S_X, 8'hC3, 8'h00, 0);
    next(); reset = 1'b1; cyc("halt6", 0, 0, S_X, 8'hC3, 8'h00, 0);
    next(); reset = 1'b0; cyc("halt_rst", 0, 0, S_I, 8'h00, 8'h00, 0);
`else
    // 2-cycle glitch must not reach hs_sync
    next(); hs_raw = 1'b1; cyc("glitch0", 0, 0, S_I, 8'h00, 8'h00, 0);
    next(); cyc("glitch1", 0, 0, S_I, 8'h00, 8'h00, 0);
    next(); hs_raw = 1'b0; cyc("glitch2", 0, 0, S_I, 8'h00, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      next(); cyc($sformatf("glitch_q%0d", i), 0, 0, S_I, 8'h00, 8'h00, 0);
    end
    // 6-cycle level: hs_sync rises 6 cycles after hs_raw, falls 6 after release
    next(); hs_raw = 1'b1; cyc("lvl0", 0, 0, S_I, 8'h00, 8'h00, 0);
    for (int i = 1; i <= 5; i++) begin
      next(); cyc($sformatf("lvl%0d", i), 0, 0, S_I, 8'h00, 8'h00, 0);
    end
    next(); hs_raw = 1'b0; cyc("lvl6", 0, 0, S_I, 8'h00, 8'h00, 1);
    for (int i = 7; i <= 11; i++) begin
      next(); cyc($sformatf("lvl%0d", i), 0, 0, S_A, 8'h00, 8'h00, 1);
    end
    next(); cyc("lvl12", 0, 0, S_A, 8'h00, 8'h00, 0);
    next(); cyc("lvl13", 1, 1, S_R, 8'h00, 8'h00, 0);
`endif
    repeat (2) @(negedge clk);
    #1;
    check_val("drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
